adder_accumulator: RTL and testbench
====================================

// Module: adder_accumulator
// PURPOSE
//   Downstream stage of the parameterised adder. Consumes the {carry,sum} result stream
//   through a valid/ready handshake and accumulates a fixed-length burst of results into
//   a wider register, saturating on overflow. Presents each burst total through a second
//   valid/ready handshake, then clears and starts the next burst.
// PARAMETERS
//   add_bit    4   width of the adder sum input; one sample = {carry,sum}, add_bit+1 bits
//   acc_bit    8   accumulator / result width; must be >= add_bit+1
//   burst_len  8   accepted samples per burst; must be >= 1
// PORTS
//   clk        in   1          single clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   clr        in   1          synchronous flush of the current burst
//   in_valid   in   1          sum/carry carry a valid sample
//   in_ready   out  1          block accepts a sample this cycle
//   sum        in   add_bit    adder sum
//   carry      in   1          adder carry-out, MSB of the sample
//   out_valid  out  1          result/ovf hold a completed burst
//   out_ready  in   1          consumer takes the result
//   result     out  acc_bit    burst total, saturated
//   ovf        out  1          sticky: saturation occurred in this burst
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): state=IDLE, acc=0, cnt=0, ovf=0.
//     Outputs during and after reset: out_valid=0, in_ready=1, result=0.
//   - Sample = {carry,sum}, zero-extended to acc_bit. Accept = in_valid & in_ready.
//   - in_ready = (state != DONE), decoded combinationally from the state.
//   - out_valid = (state == DONE). result and ovf are registered.
//   - IDLE: on accept: acc<=sample, cnt<=1, next=ACCUM. If burst_len==1, next=DONE.
//   - ACCUM: on accept: acc<=sat(acc+sample), cnt<=cnt+1.
//       The accept at cnt==burst_len-1 moves the block to DONE.
//       No accept: all state holds. Gaps in in_valid are legal.
//   - DONE: accepts no samples. When out_ready=1: acc<=0, cnt<=0, ovf<=0, next=IDLE.
//       in_ready rises on the following cycle.
//   - Latency: out_valid asserts the cycle after the final sample is accepted.
//   - Saturation: compute the sum at acc_bit+1 bits. If the MSB is set, acc<=all-ones
//     and ovf<=1. Once set, ovf stays set until the burst is handed off.
//   - clr=1 has priority over every other event, including an accept or out_ready in
//     the same cycle. It forces IDLE with acc=0, cnt=0, ovf=0, and drops any pending result.
//   - Async reset mid-burst: outputs take their reset values immediately, with no wait
//     for a clock edge. The partial burst is discarded.
//   - cnt width = $clog2(burst_len+1). cnt never exceeds burst_len.
// STRUCTURE
//   - adder_pkg holds:
//       typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
//       function sample_ext() for the {carry,sum} zero-extension.
//   - One sub-module, sat_adder #(acc_bit): combinational saturating add.
//       Outputs are the saturated sum and an overflow flag.
//   - The remaining logic stays in this module: FSM, counter, registers.
// TESTING  (add_bit=4, acc_bit=8, burst_len=8 unless noted)
//   1. Hold reset=0 for 2 cycles, then release.
//      -> out_valid=0, in_ready=1, result=0, ovf=0 during and after reset.
//   2. Send 8 samples sum=3, carry=0, in_valid gapped every other cycle.
//      -> out_valid=1 one cycle after the 8th accept, result=24, ovf=0.
//      -> out_ready=1 returns the block to IDLE.
//   3. Use acc_bit=6. Send 8 samples sum=15, carry=1 (value 31).
//      -> result=63, ovf=1. ovf first sets on the 3rd accept (31+31+31=93>63).
//   4. Complete a burst, then hold out_ready=0 for 5 cycles with in_valid=1.
//      -> in_ready=0 throughout, result=24 stable, no samples consumed.
//   5. Accept 3 samples of 5, then pulse clr in the same cycle as a 4th in_valid.
//      -> that sample is dropped, acc=0.
//      -> next 8 samples of 2 give result=16.
//   6. Drop reset between clock edges mid-burst (cnt=4), and again in DONE.
//      -> out_valid and result clear immediately in both cases.
//      -> the next full burst produces the correct total.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder result stream and its accumulator.
package adder_pkg;

    // Burst accumulator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Working width for the zero-extension helper; callers cast down to their own width.
    localparam int EXT_W = 32;

    // Build the sample value {carry,sum} from an adder result, zero-extended to EXT_W.
    // sum must already be zero-extended above add_bit.
    function automatic logic [EXT_W-1:0] sample_ext(
        input logic             carry,
        input logic [EXT_W-1:0] sum,
        input int               add_bit
    );
        logic [EXT_W-1:0] carry_ext;
        carry_ext = {{(EXT_W-1){1'b0}}, carry};
        return (carry_ext << add_bit) | sum;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating adder: a + b clamped to all-ones, with an overflow flag.
module sat_adder #(
    parameter int acc_bit = 8
) (
    input  logic [acc_bit-1:0] a_i,
    input  logic [acc_bit-1:0] b_i,
    output logic [acc_bit-1:0] sum_o,
    output logic               ovf_o
);

    // One extra bit catches the carry out of the top position.
    logic [acc_bit:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o    = full_sum[acc_bit];
    assign sum_o    = ovf_o ? {acc_bit{1'b1}} : full_sum[acc_bit-1:0];

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates fixed-length bursts of {carry,sum} adder results into a saturating
// register and hands each burst total downstream over a valid/ready handshake.
// Requires acc_bit >= add_bit+1 and burst_len >= 1.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int add_bit   = 4,
    parameter int acc_bit   = 8,
    parameter int burst_len = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [add_bit-1:0] sum,
    input  logic               carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [acc_bit-1:0] result,
    output logic               ovf
);

    localparam int               CNT_W    = $clog2(burst_len + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(burst_len - 1);

    acc_state_t         state_q, state_d;
    logic [acc_bit-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [acc_bit-1:0] sample;
    logic [acc_bit-1:0] add_sum;
    logic               add_ovf;
    logic               accept;

    assign sample = acc_bit'(sample_ext(carry, EXT_W'(sum), add_bit));
    assign accept = in_valid & in_ready;

    sat_adder #(
        .acc_bit (acc_bit)
    ) u_sat_adder (
        .a_i   (acc_q),
        .b_i   (sample),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; clr overrides every other event.
    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = (burst_len == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && (cnt_q == CNT_LAST)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load, accumulate, hand off or flush.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d = sample;
                        cnt_d = CNT_ONE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_ONE;
                        ovf_d = ovf_q | add_ovf;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_d = '0;
                        cnt_d = '0;
                        ovf_d = 1'b0;
                    end
                end
                default: begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers; result and ovf are driven straight from these.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign result = acc_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench: two accumulators (acc_bit=8 and acc_bit=6) share one stimulus
// stream; expected burst totals are queued at issue time and popped on handoff.
module tb_adder_accumulator;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic [3:0] sum;
    logic       carry;
    logic       out_ready;

    logic       in_ready8, out_valid8, ovf8;
    logic [7:0] result8;
    logic       in_ready6, out_valid6, ovf6;
    logic [5:0] result6;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [6:0] q6[$];

    adder_accumulator #(.add_bit(4), .acc_bit(8), .burst_len(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .result    (result8),
        .ovf       (ovf8)
    );

    adder_accumulator #(.add_bit(4), .acc_bit(6), .burst_len(8)) u_dut6 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .result    (result6),
        .ovf       (ovf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitors: compare each handed-off burst against the queued expectation.
    always @(negedge clk) begin
        if (reset && out_valid8 && out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out8_unexpected: got result %0d, expected no output", result8);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                check("out8_result", result8, e[7:0]);
                check("out8_ovf", ovf8, e[8]);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid6 && out_ready) begin
            if (q6.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out6_unexpected: got result %0d, expected no output", result6);
            end else begin
                logic [6:0] e;
                e = q6.pop_front();
                check("out6_result", result6, e[5:0]);
                check("out6_ovf", ovf6, e[6]);
            end
        end
    end

    // Offer one sample; returns at posedge+1 right after the accepting edge.
    task automatic put(input logic [3:0] s, input logic c);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        sum      = s;
        carry    = c;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("put_in_ready");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Eight identical samples with 'gap' idle cycles between them.
    task automatic burst(input logic [3:0] s, input logic c, input int gap,
                         input logic [7:0] e8, input logic eo8,
                         input logic [5:0] e6, input logic eo6, input bit push);
        if (push) begin
            q8.push_back({eo8, e8});
            q6.push_back({eo6, e6});
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("no_early_out_valid", out_valid8, 0);
            put(s, c);
            if (i < 7) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        check("latency_out_valid", out_valid8, 1);
    endtask

    task automatic handoff();
        bit ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("handoff_out_valid");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_out_valid_low", out_valid8, 0);
        check("handoff_in_ready_high", in_ready8, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        sum       = 4'd0;
        carry     = 1'b0;
        out_ready = 1'b0;

        // 1. Reset values during and after reset.
        #1;
        check("rst_out_valid", out_valid8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_result8", result8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_result6", result6, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid8, 0);
        check("post_rst_in_ready", in_ready8, 1);
        check("post_rst_result8", result8, 0);
        check("post_rst_ovf8", ovf8, 0);
        @(posedge clk);
        #1;

        // 2. Eight samples of 3 with gaps: 24.
        burst(4'd3, 1'b0, 1, 8'd24, 1'b0, 6'd24, 1'b0, 1'b1);
        handoff();

        // 3. Eight samples of 31: 248 at 8 bits, saturates to 63 at 6 bits on accept 3.
        q8.push_back({1'b0, 8'd248});
        q6.push_back({1'b1, 6'd63});
        for (int i = 0; i < 8; i++) begin
            put(4'd15, 1'b1);
            if (i == 1) begin
                check("sat_acc6_after2", result6, 62);
                check("sat_ovf6_after2", ovf6, 0);
            end
            if (i == 2) begin
                check("sat_acc6_after3", result6, 63);
                check("sat_ovf6_after3", ovf6, 1);
                check("sat_acc8_after3", result8, 93);
                check("sat_ovf8_after3", ovf8, 0);
            end
        end
        check("sat_out_valid", out_valid8, 1);
        handoff();

        // 4. Backpressure in DONE: no samples consumed, result stable.
        burst(4'd3, 1'b0, 0, 8'd24, 1'b0, 6'd24, 1'b0, 1'b1);
        in_valid = 1'b1;
        sum      = 4'd3;
        carry    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready8, 0);
            check("bp_result", result8, 24);
            check("bp_out_valid", out_valid8, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        handoff();

        // 5. clr in the same cycle as a 4th sample drops it and empties the burst.
        for (int i = 0; i < 3; i++) put(4'd5, 1'b0);
        check("pre_clr_acc", result8, 15);
        in_valid = 1'b1;
        sum      = 4'd5;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        check("clr_result8", result8, 0);
        check("clr_result6", result6, 0);
        check("clr_out_valid", out_valid8, 0);
        check("clr_in_ready", in_ready8, 1);
        burst(4'd2, 1'b0, 0, 8'd16, 1'b0, 6'd16, 1'b0, 1'b1);
        handoff();

        // 6a. Asynchronous reset mid-burst (cnt=4).
        for (int i = 0; i < 4; i++) put(4'd3, 1'b0);
        check("mid_acc", result8, 12);
        #2;
        reset = 1'b0;
        #1;
        check("arst_mid_out_valid", out_valid8, 0);
        check("arst_mid_result8", result8, 0);
        check("arst_mid_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 6b. Asynchronous reset while holding a completed burst.
        burst(4'd4, 1'b0, 0, 8'd32, 1'b0, 6'd32, 1'b0, 1'b0);
        check("done_result8", result8, 32);
        #2;
        reset = 1'b0;
        #1;
        check("arst_done_out_valid", out_valid8, 0);
        check("arst_done_result8", result8, 0);
        check("arst_done_result6", result6, 0);
        check("arst_done_ovf8", ovf8, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 6c. A full burst after reset totals correctly.
        burst(4'd7, 1'b0, 1, 8'd56, 1'b0, 6'd56, 1'b0, 1'b1);
        handoff();

        // Every queued expectation must have been consumed.
        begin
            bit drained;
            drained = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (q8.size() == 0 && q6.size() == 0) begin
                    drained = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!drained) bound_fail("scoreboard_drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
